// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready byte buffer feeding a START/DATA/[PARITY]/STOP framer.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register.
module uart_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic               tx_en,
    input  logic               cfg_parity_en,
    input  logic               cfg_parity_odd,
    input  logic [7:0]         cfg_br,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_level
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic       push;
    logic       pop;
    logic [7:0] head_data;

`ifdef UART_TX_FIFO_EN
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg;
    logic [FIFO_AW-1:0] rd_ptr_reg;
    logic [FIFO_AW:0]   level_reg;

    assign tx_ready   = (level_reg != (FIFO_AW+1)'(FIFO_DEPTH));
    assign push       = tx_valid & tx_ready;
    assign head_data  = mem[rd_ptr_reg];
    assign fifo_level = level_reg;

    always_ff @(posedge pclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    // Pointers are exactly FIFO_AW bits wide, so they wrap modulo the depth by themselves.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end
`else
    logic [7:0] hold_reg;
    logic       full_reg;
    logic       unused_params;

    assign tx_ready      = ~full_reg;
    assign push          = tx_valid & tx_ready;
    assign head_data     = hold_reg;
    assign fifo_level    = {{FIFO_AW{1'b0}}, full_reg};
    assign unused_params = (FIFO_DEPTH == (1 << FIFO_AW));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            hold_reg <= '0;
            full_reg <= 1'b0;
        end else if (push) begin
            hold_reg <= tx_data;
            full_reg <= 1'b1;
        end else if (pop) begin
            full_reg <= 1'b0;
        end
    end
`endif

    state_t      state_reg, state_next;
    logic [12:0] cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  data_reg, data_next;
    logic        par_en_reg, par_en_next;
    logic        par_odd_reg, par_odd_next;
    logic [7:0]  br_reg, br_next;
    logic        line_reg, line_next;
    logic        done_reg, done_next;
    logic [12:0] bit_last;
    logic        tick;
    logic        have_data;

    // 16*(br+1)-1 == {br, 4'hF}: exact in 13 bits for every divisor, no adder needed.
    assign bit_last  = {1'b0, br_reg, 4'hF};
    assign tick      = (cnt_reg == bit_last);
    assign have_data = tx_en && (fifo_level != '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = tick ? 13'd0 : cnt_reg + 13'd1;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        par_en_next  = par_en_reg;
        par_odd_next = par_odd_reg;
        br_next      = br_reg;
        line_next    = 1'b1;
        done_next    = 1'b0;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = 13'd0;
                pop      = have_data;
            end
            START: begin
                line_next = 1'b0;
                if (tick) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                line_next = shift_reg[0];
                if (tick) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                line_next = (^data_reg) ^ par_odd_reg;
                if (tick) state_next = STOP;
            end
            STOP: begin
                line_next = 1'b1;
                if (tick) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                    pop        = have_data;
                end
            end
            default: state_next = IDLE;
        endcase

        // Popping always starts a new frame with configuration frozen for its duration.
        if (pop) begin
            state_next   = START;
            cnt_next     = 13'd0;
            data_next    = head_data;
            shift_next   = head_data;
            par_en_next  = cfg_parity_en;
            par_odd_next = cfg_parity_odd;
            br_next      = cfg_br;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
            br_reg      <= '0;
            line_reg    <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            par_en_reg  <= par_en_next;
            par_odd_reg <= par_odd_next;
            br_reg      <= br_next;
            line_reg    <= line_next;
            done_reg    <= done_next;
        end
    end

    assign uart_tx = line_reg;
    assign tx_done = done_reg;
    assign tx_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: expected line levels come from a per-frame bit model.
// Buffer depth follows UART_TX_FIFO_EN (FIFO_DEPTH entries when defined, one otherwise).
module tb_uart_tx_serializer;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif

    logic             pclk = 1'b0;
    logic             preset_n;
    logic             tx_en;
    logic             cfg_parity_en;
    logic             cfg_parity_odd;
    logic [7:0]       cfg_br;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             uart_tx;
    logic             tx_busy;
    logic             tx_done;
    logic [FIFO_AW:0] fifo_level;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_tx_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)) dut (
        .pclk(pclk), .preset_n(preset_n), .tx_en(tx_en),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_br(cfg_br),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .uart_tx(uart_tx),
        .tx_busy(tx_busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot idx for a frame: start, 8 data LSB first, optional parity, stop.
    function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic po, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && pe) return (^d) ^ po;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Caller sits in frame cycle k0 (cycle 0 = first low cycle on uart_tx); ends in cycle k1.
    task automatic check_cycles(input logic [7:0] d, input logic pe, input logic po,
                                input int p, input int k0, input int k1);
        int nb;
        nb = pe ? 11 : 10;
        for (int k = k0; k <= k1; k++) begin
            if (k != k0) step();
            chk("uart_tx_bit", uart_tx, exp_bit(d, pe, po, k / p));
            chk("tx_done", tx_done, (k == nb * p - 1));
            if (k == 0) chk("tx_busy_start", tx_busy, 1);
        end
    endtask

    task automatic run_frame(input int p, input logic idle_after);
        logic [7:0] d;
        int nb;
        d  = exp_q.pop_front();
        nb = cfg_parity_en ? 11 : 10;
        check_cycles(d, cfg_parity_en, cfg_parity_odd, p, 0, nb * p - 1);
        $display("frame data=%02h parity_en=%0d odd=%0d period=%0d", d, cfg_parity_en, cfg_parity_odd, p);
        if (idle_after) begin
            step();
            chk("idle_line", uart_tx, 1);
            chk("idle_done", tx_done, 0);
            chk("idle_busy", tx_busy, 0);
        end
    endtask

    task automatic wait_fall(input int limit);
        for (int i = 0; i < limit && uart_tx !== 1'b0; i++) step();
        chk("start_edge_seen", uart_tx, 0);
    endtask

    task automatic push(input logic [7:0] d);
        for (int i = 0; i < 20000 && tx_ready !== 1'b1; i++) step();
        chk("tx_ready_wait", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge pclk);
        #1;
        tx_valid = 1'b0;
        exp_q.push_back(d);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;

        preset_n = 1'b0; tx_en = 1'b0; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
        cfg_br = 8'd0; tx_data = 8'd0; tx_valid = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_level", fifo_level, 0);
        @(negedge pclk);
        preset_n = 1'b1;
        step();

        // br=0, no parity, 0x55: line low two edges after the push edge.
        tx_en = 1'b1;
        tx_data = 8'h55; tx_valid = 1'b1;
        @(posedge pclk);
        #1;
        tx_valid = 1'b0;
        exp_q.push_back(8'h55);
        chk("lat_push_edge", uart_tx, 1);
        chk("level_after_push", fifo_level, 1);
        step();
        chk("lat_pop_edge", uart_tx, 1);
        step();
        chk("lat_start", uart_tx, 0);
        run_frame(16, 1'b1);

        // Parity even / odd on 0x03.
        cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        push(8'h03); wait_fall(4); run_frame(16, 1'b1);
        cfg_parity_odd = 1'b1;
        push(8'h03); wait_fall(4); run_frame(16, 1'b1);

        // Random single frames with random divisor and parity settings.
        for (int t = 0; t < 4; t++) begin
            cfg_br         = 8'($urandom_range(0, 3));
            cfg_parity_en  = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            push(8'($urandom));
            wait_fall(4);
            run_frame(16 * (int'(cfg_br) + 1), 1'b1);
        end

        // Four bytes pushed back-to-back at br=1: frames must follow with no idle gap.
        cfg_br = 8'd1;
        cfg_parity_en = 1'b0;
        fork
            begin
                for (int j = 0; j < 4; j++) push(8'($urandom));
`ifdef UART_TX_FIFO_EN
                chk("level_peak", fifo_level, 3);
`endif
            end
            begin
                wait_fall(8);
                for (int j = 0; j < 4; j++) begin
                    if (j != 0) step();
                    run_frame(32, (j == 3));
                end
            end
        join

        // tx_en low: fill the buffer plus one extra; the extra must be dropped.
        tx_en = 1'b0;
        cfg_br = 8'd0;
        cfg_parity_en = 1'($urandom_range(0, 1));
        for (int i = 0; i <= DEPTH; i++) begin
            tx_data  = 8'($urandom);
            tx_valid = 1'b1;
            chk("ready_fill", tx_ready, (i < DEPTH));
            if (i < DEPTH) exp_q.push_back(tx_data);
            step();
        end
        tx_valid = 1'b0;
        chk("level_full", fifo_level, DEPTH);
        chk("ready_full", tx_ready, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_idle_line", uart_tx, 1);
            step();
        end
        tx_en = 1'b1;
        wait_fall(4);
        for (int j = 0; j < DEPTH; j++) begin
            if (j != 0) step();
            run_frame(16, (j == DEPTH - 1));
        end
        chk("level_drained", fifo_level, 0);
        for (int i = 0; i < 40; i++) begin
            chk("no_extra_frame", uart_tx, 1);
            step();
        end

        // Mid-frame: change divisor and drop tx_en; frame keeps old period, next byte waits.
        cfg_br = 8'd2;
        cfg_parity_en = 1'b0;
        push(8'($urandom));
        push(8'($urandom));
        wait_fall(4);
        a = exp_q.pop_front();
        check_cycles(a, 1'b0, 1'b0, 48, 0, 3 * 48 + 5);
        cfg_br = 8'd0;
        tx_en = 1'b0;
        check_cycles(a, 1'b0, 1'b0, 48, 3 * 48 + 5, 479);
        $display("frame data=%02h period=48 with mid-frame cfg change", a);
        for (int i = 0; i < 64; i++) begin
            step();
            chk("no_next_frame", uart_tx, 1);
        end
        chk("level_pending", fifo_level, 1);

        // Re-enable, then reset in the middle of the pending frame.
        tx_en = 1'b1;
        wait_fall(4);
        b = exp_q.pop_front();
        check_cycles(b, 1'b0, 1'b0, 16, 0, 40);
        push(8'($urandom));
        chk("level_before_rst", fifo_level, 1);
        preset_n = 1'b0;
        #1;
        chk("rst_mid_uart_tx", uart_tx, 1);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_done", tx_done, 0);
        exp_q.delete();
        $display("reset asserted mid-frame of data=%02h", b);
        @(negedge pclk);
        preset_n = 1'b1;
        repeat (4) step();
        chk("post_rst_idle", uart_tx, 1);

        // Slowest divisor: 4096-cycle bit period.
        cfg_br = 8'd255;
        push(8'($urandom));
        wait_fall(4);
        run_frame(4096, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
